dds_phase_addr_gen: RTL and testbench
=====================================

# dds_phase_addr_gen

Phase-accumulator front end of the DDS datapath: integrates a frequency tuning word, adds a phase offset and optional LFSR dither, and drives the address of the minus-sine/sine lookup ROMs. It also runs a linear upward frequency sweep and emits a `sample_valid` aligned to the registered ROM output. It is the initiator side of the ROM address interface and shares that interface's `clk`/`ce`/`rst` semantics.

## Interface
- `PHASE_WIDTH`, 32, accumulator/FTW/POW width
- `ROM_ADDR_WIDTH`, 12, ROM address width; must satisfy `PHASE_WIDTH - ROM_ADDR_WIDTH >= DITHER_WIDTH`
- `DITHER_WIDTH`, 4, dither bits injected below the truncation point
- `ROM_LATENCY`, 1, ROM read latency in `ce` cycles
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `ce`  in  1  clock enable; shared with ROMs; nothing advances when low
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  config accepted when `cfg_valid && cfg_ready` at a posedge (independent of `ce`)
- `cfg_ftw`  in  PHASE_WIDTH  start tuning word
- `cfg_ftw_end`  in  PHASE_WIDTH  sweep end tuning word
- `cfg_step`  in  PHASE_WIDTH  per-sample sweep increment
- `cfg_pow`  in  PHASE_WIDTH  phase offset
- `cfg_sweep`  in  1  1 = sweep, 0 = fixed
- `cfg_phase_rst`  in  1  clear accumulator on accept
- `dither_en`  in  1  enable dither
- `stop`  in  1  return to IDLE
- `addr`  out  ROM_ADDR_WIDTH  ROM address, registered
- `addr_valid`  out  1  `addr` is a live sample
- `sample_valid`  out  1  ROM output valid (`addr_valid` delayed by `ROM_LATENCY` ce-cycles)
- `wrap`  out  1  one-`ce`-cycle pulse on accumulator carry-out
- `sweep_done`  out  1  one-`ce`-cycle pulse on SWEEP→HOLD

## Operation
- States: IDLE, RUN, SWEEP, HOLD. Reset → IDLE; acc, ftw_cur, pow, addr = 0; addr_valid, sample_valid, wrap, sweep_done = 0; LFSR = 16'hACE1.
- `cfg_ready` = 1 in IDLE, RUN, HOLD; 0 in SWEEP.
- Accept: ftw_cur ← cfg_ftw, pow ← cfg_pow. acc ← 0 if `cfg_phase_rst` or state is IDLE, otherwise acc is kept (phase-continuous retune).
  - Next state is SWEEP if `cfg_sweep && cfg_step != 0 && cfg_ftw < cfg_ftw_end` (unsigned compare).
  - Next state is HOLD if `cfg_sweep` and that condition fails.
  - Otherwise next state is RUN.
- Per `ce` cycle in RUN/SWEEP/HOLD:
  - addr ← top ROM_ADDR_WIDTH bits of (acc + pow + d), modulo 2^PHASE_WIDTH.
  - acc ← acc + ftw_cur; `wrap` ← carry of that add.
  - addr_valid ← 1.
- Dither d: LFSR low DITHER_WIDTH bits, left-shifted by `PHASE_WIDTH - ROM_ADDR_WIDTH - DITHER_WIDTH`. d = 0 when `dither_en` = 0. The LFSR advances only on `ce` with `dither_en`.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
- SWEEP: each `ce` cycle, if ftw_cur + cfg_step ≥ ftw_end (saturated, no overflow) then ftw_cur ← ftw_end, state ← HOLD, `sweep_done` pulses; otherwise ftw_cur ← ftw_cur + step.
- `stop` (priority over `cfg_valid`): state ← IDLE at the next posedge regardless of `ce`. addr_valid ← 0 and acc is held. The sample_valid pipe drains on subsequent `ce` cycles.
- In IDLE, addr holds its last value and addr_valid = 0.

## Timing
- Config takes effect at the posedge after acceptance.
- With `ce` held high, addr reflects acc at that edge, i.e. the phase before the update.
- First addr after a reset-acc accept = pow[top] (+dither). addr_valid rises at the same edge.
- sample_valid = addr_valid delayed by ROM_LATENCY `ce`-qualified stages. With `ce` low, all pipes freeze.
- `wrap` and `sweep_done` are registered and held exactly one `ce` cycle.
- `rst` mid-operation: all state clears immediately to reset values.

## Structure
- Package `dds_pkg`:
  - state enum `dds_state_t`
  - constants `LFSR_SEED` = 16'hACE1 and `LFSR_TAPS` = 16'hB400
- Sub-module `dds_lfsr` (16-bit Galois LFSR with enable and seed).
- Top module holds the FSM, accumulator, sweep adder/saturator and valid delay line.

## Test plan
All scenarios use PHASE_WIDTH=16, ROM_ADDR_WIDTH=12, DITHER_WIDTH=4, ROM_LATENCY=1, `ce`=1 unless stated.
- Fixed tone: ftw=16'h0100, pow=0, phase_rst → addr 0,16,32,…; `wrap` after 256 samples; sample_valid one cycle after addr_valid.
- Offset + `ce` gating: pow=16'h8000, ftw=16'h0010 → first addr=2048, +1 each sample. `ce` toggling 1010 → addr advances only on `ce`=1.
- Sweep: ftw=16'h0010, step=16'h0010, ftw_end=16'h0040 → increments 1,2,3,4 (in address LSBs); `sweep_done` on the 3rd step; HOLD at 16'h0040; `cfg_ready` low during SWEEP.
- Degenerate sweep: step=0 or ftw_end ≤ ftw with `cfg_sweep`=1 → HOLD immediately at cfg_ftw, no `sweep_done`.
- Retune without phase_rst mid-RUN → acc continuous (no phase jump); `stop` → addr_valid low at the next edge, sample_valid low one `ce` later.
- Dither: `dither_en`=1, ftw=0 → addr ∈ {0,1}, matching a reference LFSR from seed ACE1. Assert `rst` asynchronously mid-sweep → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase/address generator.
// The LFSR step is the right-shifting Galois form of x^16+x^14+x^13+x^11+1.
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_HOLD  = 2'd3
  } dds_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/dds_lfsr.sv
// 16-bit Galois LFSR with enable; exposes only the low OUT_W bits used as dither.
module dds_lfsr
  import dds_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [15:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

  assign q = state[OUT_W-1:0];

endmodule

// File: rtl/dds_phase_addr_gen.sv
// DDS phase accumulator front end: FTW integration, phase offset, LFSR dither,
// linear upward frequency sweep and a ROM-latency-matched sample valid.
module dds_phase_addr_gen
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int DITHER_WIDTH   = 4,
  parameter int ROM_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PHASE_WIDTH-1:0]    cfg_ftw,
  input  logic [PHASE_WIDTH-1:0]    cfg_ftw_end,
  input  logic [PHASE_WIDTH-1:0]    cfg_step,
  input  logic [PHASE_WIDTH-1:0]    cfg_pow,
  input  logic                      cfg_sweep,
  input  logic                      cfg_phase_rst,
  input  logic                      dither_en,
  input  logic                      stop,
  output logic [ROM_ADDR_WIDTH-1:0] addr,
  output logic                      addr_valid,
  output logic                      sample_valid,
  output logic                      wrap,
  output logic                      sweep_done
);

  localparam int FRAC_W = PHASE_WIDTH - ROM_ADDR_WIDTH;
  localparam int DSH    = FRAC_W - DITHER_WIDTH;

  // Saturating sweep increment: MSB flags that the end word was reached.
  function automatic logic [PHASE_WIDTH:0] sat_step(
    input logic [PHASE_WIDTH-1:0] cur,
    input logic [PHASE_WIDTH-1:0] inc,
    input logic [PHASE_WIDTH-1:0] lim
  );
    logic [PHASE_WIDTH:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum >= {1'b0, lim}) begin
      return {1'b1, lim};
    end
    return {1'b0, sum[PHASE_WIDTH-1:0]};
  endfunction

  // Truncate a full phase word to the ROM address (drop fractional bits).
  function automatic logic [ROM_ADDR_WIDTH-1:0] quant_addr(input logic [PHASE_WIDTH-1:0] ph);
    return ROM_ADDR_WIDTH'(ph >> FRAC_W);
  endfunction

  dds_state_t state, state_nxt;

  logic [PHASE_WIDTH-1:0]  acc;
  logic [PHASE_WIDTH-1:0]  ftw_cur;
  logic [PHASE_WIDTH-1:0]  ftw_end;
  logic [PHASE_WIDTH-1:0]  step;
  logic [PHASE_WIDTH-1:0]  pow;
  logic [ROM_LATENCY-1:0]  vld_p;

  logic [DITHER_WIDTH-1:0] dither_bits;
  logic [PHASE_WIDTH-1:0]  dither_p0;
  logic [PHASE_WIDTH-1:0]  acc_sum_p0;
  logic                    carry_p0;
  logic [PHASE_WIDTH-1:0]  sweep_nxt_p0;
  logic                    sweep_hit_p0;
  logic                    accept;
  logic                    sweep_ok;
  logic                    active;

  dds_lfsr #(
    .OUT_W (DITHER_WIDTH)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (ce & dither_en),
    .q   (dither_bits)
  );

  assign cfg_ready = (state != ST_SWEEP);
  assign accept    = cfg_valid && cfg_ready && !stop;
  assign sweep_ok  = (cfg_step != '0) && (cfg_ftw < cfg_ftw_end);
  assign active    = (state != ST_IDLE);

  // Stage p0: combinational phase arithmetic feeding the registered outputs
  assign dither_p0                  = dither_en ? (PHASE_WIDTH'(dither_bits) << DSH) : '0;
  assign {carry_p0, acc_sum_p0}     = {1'b0, acc} + {1'b0, ftw_cur};
  assign {sweep_hit_p0, sweep_nxt_p0} = sat_step(ftw_cur, step, ftw_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stop and configuration act on any edge; the sweep only advances on ce.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else if (accept) begin
      if (cfg_sweep) begin
        state_nxt = sweep_ok ? ST_SWEEP : ST_HOLD;
      end else begin
        state_nxt = ST_RUN;
      end
    end else if (ce && (state == ST_SWEEP) && sweep_hit_p0) begin
      state_nxt = ST_HOLD;
    end
  end

  // Stage p1: registered address, accumulator, pulses and valid delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      ftw_cur    <= '0;
      ftw_end    <= '0;
      step       <= '0;
      pow        <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
      sweep_done <= 1'b0;
      vld_p      <= '0;
    end else begin
      if (ce) begin
        vld_p      <= ROM_LATENCY'({vld_p, addr_valid});
        wrap       <= 1'b0;
        sweep_done <= 1'b0;
        if (active && !stop) begin
          addr       <= quant_addr(acc + pow + dither_p0);
          acc        <= acc_sum_p0;
          wrap       <= carry_p0;
          addr_valid <= 1'b1;
          if (state == ST_SWEEP) begin
            ftw_cur    <= sweep_nxt_p0;
            sweep_done <= sweep_hit_p0;
          end
        end
      end
      // A retune without phase reset lets the accumulator keep integrating.
      if (stop) begin
        addr_valid <= 1'b0;
      end else if (accept) begin
        ftw_cur <= cfg_ftw;
        ftw_end <= cfg_ftw_end;
        step    <= cfg_step;
        pow     <= cfg_pow;
        if (cfg_phase_rst || (state == ST_IDLE)) begin
          acc <= '0;
        end
      end
    end
  end

  assign sample_valid = vld_p[ROM_LATENCY-1];

endmodule

// File: tb/tb_dds_phase_addr_gen.sv
// Directed bench for dds_phase_addr_gen with PHASE_WIDTH=16, ROM_ADDR_WIDTH=12.
module tb_dds_phase_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_ftw, cfg_ftw_end, cfg_step, cfg_pow;
  logic        cfg_sweep, cfg_phase_rst, dither_en, stop;
  logic [11:0] addr;
  logic        addr_valid, sample_valid, wrap, sweep_done;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_lfsr;
  logic [31:0] exp_a;

  dds_phase_addr_gen #(
    .PHASE_WIDTH    (16),
    .ROM_ADDR_WIDTH (12),
    .DITHER_WIDTH   (4),
    .ROM_LATENCY    (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ftw       (cfg_ftw),
    .cfg_ftw_end   (cfg_ftw_end),
    .cfg_step      (cfg_step),
    .cfg_pow       (cfg_pow),
    .cfg_sweep     (cfg_sweep),
    .cfg_phase_rst (cfg_phase_rst),
    .dither_en     (dither_en),
    .stop          (stop),
    .addr          (addr),
    .addr_valid    (addr_valid),
    .sample_valid  (sample_valid),
    .wrap          (wrap),
    .sweep_done    (sweep_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic adv;
    adv = ce && dither_en;
    @(posedge clk);
    if (adv) m_lfsr = ref_lfsr(m_lfsr);
    #1;
  endtask

  task automatic cfg(input logic [15:0] ftw, input logic [15:0] fend, input logic [15:0] stp,
                     input logic [15:0] pw, input logic sw, input logic prst);
    cfg_ftw       = ftw;
    cfg_ftw_end   = fend;
    cfg_step      = stp;
    cfg_pow       = pw;
    cfg_sweep     = sw;
    cfg_phase_rst = prst;
    cfg_valid     = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_addr"},   32'(addr), 32'h0);
    chk({tag, "_av"},     32'(addr_valid), 32'h0);
    chk({tag, "_sv"},     32'(sample_valid), 32'h0);
    chk({tag, "_wrap"},   32'(wrap), 32'h0);
    chk({tag, "_sdone"},  32'(sweep_done), 32'h0);
    chk({tag, "_ready"},  32'(cfg_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; cfg_valid = 1'b0; stop = 1'b0; dither_en = 1'b0;
    cfg_ftw = '0; cfg_ftw_end = '0; cfg_step = '0; cfg_pow = '0;
    cfg_sweep = 1'b0; cfg_phase_rst = 1'b0;
    m_lfsr = 16'hACE1;
    repeat (2) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Fixed tone: addr steps by 16, wrap on the 256th update
    cfg(16'h0100, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("tone_av_accept", 32'(addr_valid), 32'h0);
    for (int k = 1; k <= 257; k++) begin
      tick();
      chk($sformatf("tone_addr[%0d]", k), 32'(addr), ((k - 1) * 16) & 32'hFFF);
      chk($sformatf("tone_av[%0d]", k), 32'(addr_valid), 32'h1);
      chk($sformatf("tone_sv[%0d]", k), 32'(sample_valid), (k >= 2) ? 32'h1 : 32'h0);
      chk($sformatf("tone_wrap[%0d]", k), 32'(wrap), (k == 256) ? 32'h1 : 32'h0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_av", 32'(addr_valid), 32'h0);
    chk("stop_sv", 32'(sample_valid), 32'h1);
    chk("stop_addr_hold", 32'(addr), 32'h0);
    tick();
    chk("stop_sv_drain", 32'(sample_valid), 32'h0);
    chk("stop_ready", 32'(cfg_ready), 32'h1);

    // Phase offset and ce gating
    cfg(16'h0010, 16'h0, 16'h0, 16'h8000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("pow_addr[%0d]", k), 32'(addr), 32'd2048 + 32'(k));
    end
    ce = 1'b0; tick(); chk("ce0_hold_a", 32'(addr), 32'd2050);
    chk("ce0_av", 32'(addr_valid), 32'h1);
    ce = 1'b1; tick(); chk("ce1_adv_a", 32'(addr), 32'd2051);
    ce = 1'b0; tick(); chk("ce0_hold_b", 32'(addr), 32'd2051);
    ce = 1'b1; tick(); chk("ce1_adv_b", 32'(addr), 32'd2052);

    // Retune mid-RUN without phase reset: phase keeps integrating
    cfg(16'h0020, 16'h0, 16'h0, 16'h8000, 1'b0, 1'b0);
    chk("retune_addr0", 32'(addr), 32'd2053);
    tick(); chk("retune_addr1", 32'(addr), 32'd2054);
    tick(); chk("retune_addr2", 32'(addr), 32'd2056);
    tick(); chk("retune_addr3", 32'(addr), 32'd2058);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop2_av", 32'(addr_valid), 32'h0);
    tick();
    chk("stop2_sv", 32'(sample_valid), 32'h0);

    // Linear sweep 0x10 -> 0x40 in steps of 0x10
    cfg(16'h0010, 16'h0040, 16'h0010, 16'h0, 1'b1, 1'b1);
    chk("sweep_ready_lo", 32'(cfg_ready), 32'h0);
    tick(); chk("sweep_a1", 32'(addr), 32'd0);  chk("sweep_rdy1", 32'(cfg_ready), 32'h0);
    chk("sweep_done1", 32'(sweep_done), 32'h0);
    tick(); chk("sweep_a2", 32'(addr), 32'd1);  chk("sweep_rdy2", 32'(cfg_ready), 32'h0);
    chk("sweep_done2", 32'(sweep_done), 32'h0);
    tick(); chk("sweep_a3", 32'(addr), 32'd3);  chk("sweep_done3", 32'(sweep_done), 32'h1);
    chk("hold_ready", 32'(cfg_ready), 32'h1);
    tick(); chk("sweep_a4", 32'(addr), 32'd6);  chk("sweep_done4", 32'(sweep_done), 32'h0);
    tick(); chk("hold_a5", 32'(addr), 32'd10);
    tick(); chk("hold_a6", 32'(addr), 32'd14);

    // Degenerate sweeps go straight to HOLD at cfg_ftw
    cfg(16'h0030, 16'h0020, 16'h0010, 16'h0, 1'b1, 1'b1);
    chk("degen_end_ready", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("degen_end_a[%0d]", k), 32'(addr), 32'(3 * k));
      chk($sformatf("degen_end_sd[%0d]", k), 32'(sweep_done), 32'h0);
    end
    cfg(16'h0010, 16'h0040, 16'h0000, 16'h0, 1'b1, 1'b1);
    chk("degen_step_ready", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("degen_step_a[%0d]", k), 32'(addr), 32'(k));
      chk($sformatf("degen_step_sd[%0d]", k), 32'(sweep_done), 32'h0);
    end

    // Dither with ftw=0, pow=8: addr is 1 exactly when LFSR bit 3 is set
    dither_en = 1'b1;
    cfg(16'h0000, 16'h0, 16'h0, 16'h0008, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      exp_a = (32'd8 + 32'(m_lfsr[3:0])) >> 4;
      tick();
      chk($sformatf("dither_a[%0d]", k), 32'(addr), exp_a);
    end
    dither_en = 1'b0;

    // Asynchronous reset in the middle of a sweep
    cfg(16'h0010, 16'hF000, 16'h0010, 16'h1000, 1'b1, 1'b1);
    tick(); chk("pre_rst_a1", 32'(addr), 32'h100);
    tick(); chk("pre_rst_a2", 32'(addr), 32'h101);
    tick(); chk("pre_rst_a3", 32'(addr), 32'h103);
    chk("pre_rst_ready", 32'(cfg_ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    m_lfsr = 16'hACE1;
    tick();
    rst = 1'b0;

    // LFSR restarts from its seed after reset
    dither_en = 1'b1;
    cfg(16'h0000, 16'h0, 16'h0, 16'h0008, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp_a = (32'd8 + 32'(m_lfsr[3:0])) >> 4;
      tick();
      chk($sformatf("post_rst_dither[%0d]", k), 32'(addr), exp_a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
